stackcalc_feeder: RTL and testbench
===================================

# stackcalc_feeder

Upstream driver for `davidsiaw_stackcalc`. It buffers 4-bit command/data nibbles written by a host on the fast system clock. It replays them one at a time into the calculator's `io_in`, generating the calculator's slow clock (`io_in[0]`), reset (`io_in[1]`) and data (`io_in[5:2]`). This lets a bench or on-chip sequencer stream a whole program without hand-toggling the calculator clock.

## Interface
Parameters:
- `DEPTH`, 8: nibble FIFO entries; power of two, ≥2.
- `DIV`, 4: system clocks per calc-clock half period; ≥1.

Ports:
- `clk` in 1: system clock. One clock domain only.
- `rst` in 1: reset, synchronous, active-high.
- `wr_valid` in 1: host offers `wr_data`.
- `wr_data` in 4: nibble to enqueue.
- `wr_ready` out 1: FIFO can accept this cycle.
- `rst_req` in 1: one-cycle pulse requesting a calculator reset sequence.
- `calc_io_in` out 8: `{2'b00, data[3:0], calc_rst, calc_clk}`. Wired straight to the calculator's `io_in`.
- `calc_io_out` in 8: calculator's `io_out`. Used only with capture enabled.
- `busy` out 1: a nibble or reset sequence is in flight.
- `level` out `$clog2(DEPTH+1)`: FIFO occupancy.
- `result` out 8: last captured `calc_io_out`. Only present with capture enabled.
- `result_valid` out 1: one-cycle strobe when `result` updates. Only present with capture enabled.

## Operation
- Handshake: a push occurs when `wr_valid && wr_ready`. `wr_ready = (level != DEPTH)`. There is no bypass, so a push while full is dropped even if a pop occurs that cycle.
- A simultaneous push and pop leaves `level` unchanged.
- FSM states and transitions:
  - IDLE: `calc_clk=0`.
    - If a reset request is pending, go to RST_LO.
    - Else if FIFO is non-empty, pop the head into `data`, then go to LO.
  - LO: `calc_clk=0` for DIV cycles, with `data` stable. Then go to HI.
  - HI: `calc_clk=1` for DIV cycles. The calculator samples `data` on this rising edge. Then return to IDLE.
  - RST_LO / RST_HI: `calc_rst=1` while toggling `calc_clk` as in LO/HI, for exactly 2 calc-clock periods. Then drop `calc_rst` and return to IDLE.
- `rst_req` is latched into a pending flag and is only serviced from IDLE. It therefore never truncates a nibble in flight. Pending requests take priority over FIFO data.
- The reset sequence does not flush the FIFO.
- Multiple `rst_req` pulses before service collapse into one request.
- `data` holds its last value when idle.
- `busy` = state ≠ IDLE or reset pending.
- Half-period counter: width `$clog2(DIV+1)`, reloaded on every state entry.

## Timing
- Reset values:
  - `calc_io_in = 8'h00`
  - `wr_ready = 1`
  - `level = 0`
  - `busy = 0`
  - `result = 8'h00`
  - `result_valid = 0`
  - FIFO empty, no reset pending.
- `rst` asserted mid-nibble or mid-sequence aborts immediately. The next cycle shows the reset values.
- Pop-to-`calc_io_in` data: the cycle after leaving IDLE, i.e. registered.
- Rising `calc_clk` occurs DIV cycles after the data change.
- One nibble costs 2·DIV+1 system cycles. The +1 is the IDLE pop cycle.
- The FIFO wraps pointers modulo DEPTH. It has one extra occupancy bit, via `level`.

## Configuration
- `STACKCALC_FEEDER_CAPTURE_EN`
  - Defined: on the HI→IDLE transition, `result <= calc_io_out` and `result_valid` pulses for 1 cycle.
  - Undefined: the `result`/`result_valid` ports and their logic are omitted, and `calc_io_out` is left unconnected.

## Structure
- Package `stackcalc_pkg`:
  - `nibble_t` (logic [3:0])
  - FSM state enum `feeder_state_t` (IDLE, LO, HI, RST_LO, RST_HI)
  - constant `RST_PERIODS = 2`
- Sub-module `stackcalc_nibble_fifo`: DEPTH-parameterised synchronous FIFO with push/pop/level. `stackcalc_feeder` instantiates it once.

## Test plan
- Reset: hold `rst` 3 cycles. Check `calc_io_in=8'h00`, `level=0`, `wr_ready=1`, `busy=0`.
- Single nibble, DIV=4: push 4'hA.
  - Data bits are `4'hA` from cycle 2.
  - `calc_clk` is high on cycles 6–9.
  - Back to IDLE at cycle 10.
  - Total 9 cycles per nibble.
- Full FIFO, DEPTH=8: push 9 nibbles back-to-back with no drain; hold FSM busy via a pending `rst_req`.
  - 9th is refused (`wr_ready=0`).
  - `level=8`.
  - Replay order matches 0..7.
- Reset request during nibble: pulse `rst_req` mid-HI.
  - The current nibble completes.
  - Then `calc_rst=1` for exactly 2 calc-clock periods.
  - Queued nibbles resume afterwards.
- Sync reset mid-LO: assert `rst`. Next cycle `calc_io_in=8'h00`, `level=0`, and nothing further is emitted.
- Capture (macro defined): drive `calc_io_out=8'h3C` during HI.
  - `result=8'h3C`.
  - `result_valid` is high for exactly 1 cycle at HI→IDLE.

Source files
------------

// File: rtl/stackcalc_pkg.sv
// Shared types and constants for the stackcalc feeder and its nibble FIFO.
package stackcalc_pkg;

    typedef logic [3:0] nibble_t;

    typedef enum logic [2:0] {
        IDLE,
        LO,
        HI,
        RST_LO,
        RST_HI
    } feeder_state_t;

    localparam int unsigned RST_PERIODS = 2;

endpackage

// File: rtl/stackcalc_nibble_fifo.sv
// Synchronous nibble FIFO: pointers wrap modulo DEPTH, occupancy tracked in a level counter.
module stackcalc_nibble_fifo
    import stackcalc_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  nibble_t                      push_data,
    input  logic                         pop,
    output nibble_t                      head_c,
    output logic                         empty_c,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH + 1);

    nibble_t         mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [LW-1:0]   level_next;
    logic            do_push;
    logic            do_pop;

    // No bypass: a push while full is dropped even if a pop happens the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty_c;
    assign empty_c = (level == '0);
    assign head_c  = mem[rd_ptr];

    always_comb begin
        level_next = level;
        if (do_push && !do_pop) begin
            level_next = level + LW'(1);
        end else if (!do_push && do_pop) begin
            level_next = level - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level <= level_next;
            full  <= (level_next == LW'(DEPTH));
        end
    end

endmodule

// File: rtl/stackcalc_feeder.sv
// Replays buffered nibbles into the stackcalc io_in, generating its slow clock and reset.
// Optional result capture on the falling half is enabled by STACKCALC_FEEDER_CAPTURE_EN.
module stackcalc_feeder
    import stackcalc_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned DIV   = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_valid,
    input  logic [3:0]                   wr_data,
    output logic                         wr_ready,
    input  logic                         rst_req,
    output logic [7:0]                   calc_io_in,
    input  logic [7:0]                   calc_io_out,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   level
`ifdef STACKCALC_FEEDER_CAPTURE_EN
    ,
    output logic [7:0]                   result,
    output logic                         result_valid
`endif
);

    localparam int unsigned CW = $clog2(DIV + 1);
    localparam int unsigned PW = $clog2(RST_PERIODS + 1);
    localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

    feeder_state_t  state;
    feeder_state_t  state_next;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_next;
    logic [PW-1:0]  per;
    logic [PW-1:0]  per_next;
    logic           pend;
    logic           pend_next;
    logic           pop_c;
    logic           cap_c;
    logic           half_done_c;
    nibble_t        data;
    nibble_t        head_c;
    logic           empty_c;
    logic           full;
    logic           calc_clk;
    logic           calc_rst;

    stackcalc_nibble_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_valid),
        .push_data (wr_data),
        .pop       (pop_c),
        .head_c    (head_c),
        .empty_c   (empty_c),
        .full      (full),
        .level     (level)
    );

    assign wr_ready    = !full;
    assign half_done_c = (cnt == '0);
    assign calc_io_in  = {2'b00, data, calc_rst, calc_clk};

    // Reset requests are only serviced from IDLE and win over queued data.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        per_next   = per;
        pend_next  = pend || rst_req;
        pop_c      = 1'b0;
        cap_c      = 1'b0;
        case (state)
            IDLE: begin
                if (pend) begin
                    state_next = RST_LO;
                    cnt_next   = RELOAD;
                    per_next   = '0;
                    pend_next  = rst_req;
                end else if (!empty_c) begin
                    state_next = LO;
                    cnt_next   = RELOAD;
                    pop_c      = 1'b1;
                end
            end
            LO: begin
                cnt_next = cnt - CW'(1);
                if (half_done_c) begin
                    state_next = HI;
                    cnt_next   = RELOAD;
                end
            end
            HI: begin
                cnt_next = cnt - CW'(1);
                if (half_done_c) begin
                    state_next = IDLE;
                    cnt_next   = RELOAD;
                    cap_c      = 1'b1;
                end
            end
            RST_LO: begin
                cnt_next = cnt - CW'(1);
                if (half_done_c) begin
                    state_next = RST_HI;
                    cnt_next   = RELOAD;
                end
            end
            RST_HI: begin
                cnt_next = cnt - CW'(1);
                if (half_done_c) begin
                    cnt_next = RELOAD;
                    if (per == PW'(RST_PERIODS - 1)) begin
                        state_next = IDLE;
                    end else begin
                        state_next = RST_LO;
                        per_next   = per + PW'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = RELOAD;
            end
        endcase
    end

    // Outputs are registered from next-state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            per      <= '0;
            pend     <= 1'b0;
            data     <= '0;
            calc_clk <= 1'b0;
            calc_rst <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            per      <= per_next;
            pend     <= pend_next;
            if (pop_c) begin
                data <= head_c;
            end
            calc_clk <= (state_next == HI) || (state_next == RST_HI);
            calc_rst <= (state_next == RST_LO) || (state_next == RST_HI);
            busy     <= (state_next != IDLE) || pend_next;
        end
    end

`ifdef STACKCALC_FEEDER_CAPTURE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= cap_c;
            if (cap_c) begin
                result <= calc_io_out;
            end
        end
    end
`else
    logic unused_capture;
    assign unused_capture = ^{calc_io_out, cap_c};
`endif

endmodule

// File: tb/tb_stackcalc_feeder.sv
// Self-checking bench for stackcalc_feeder: waveform-queue reference model plus directed literal checks.
`timescale 1ns/1ps
module tb_stackcalc_feeder;

    localparam int unsigned DEPTH   = 8;
    localparam int unsigned DIV     = 4;
    localparam int unsigned LW      = $clog2(DEPTH + 1);
    localparam int unsigned RST_PER = 2;

    logic          clk;
    logic          rst;
    logic          wr_valid;
    logic [3:0]    wr_data;
    logic          wr_ready;
    logic          rst_req;
    logic [7:0]    calc_io_in;
    logic [7:0]    calc_io_out;
    logic          busy;
    logic [LW-1:0] level;
`ifdef STACKCALC_FEEDER_CAPTURE_EN
    logic [7:0]    result;
    logic          result_valid;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    stackcalc_feeder #(
        .DEPTH (DEPTH),
        .DIV   (DIV)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_valid     (wr_valid),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .rst_req      (rst_req),
        .calc_io_in   (calc_io_in),
        .calc_io_out  (calc_io_out),
        .busy         (busy),
        .level        (level)
`ifdef STACKCALC_FEEDER_CAPTURE_EN
        ,
        .result       (result),
        .result_valid (result_valid)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: FIFO as a queue, and the calculator-side waveform as a queue of
    // future io_in values {last_hi_of_nibble, io_in[7:0]} expanded whenever the feeder is idle.
    logic [3:0] q[$];
    logic [8:0] wave[$];
    bit         m_valid = 1'b0;
    bit         m_idle;
    bit         m_pend;
    bit         cur_last;
    bit         exp_rv;
    logic [3:0] m_data;
    logic [7:0] exp_io;
    logic [7:0] exp_res;

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            wave.delete();
            m_valid  = 1'b1;
            m_idle   = 1'b1;
            m_pend   = 1'b0;
            cur_last = 1'b0;
            exp_rv   = 1'b0;
            m_data   = 4'h0;
            exp_io   = 8'h00;
            exp_res  = 8'h00;
        end else if (m_valid) begin
            bit         acc;
            logic [3:0] d;
            logic [8:0] w;
            acc    = wr_valid && (q.size() < DEPTH);
            exp_rv = 1'b0;
            if (cur_last) begin
                exp_rv  = 1'b1;
                exp_res = calc_io_out;
            end
            if (m_idle) begin
                if (m_pend) begin
                    for (int p = 0; p < RST_PER; p++) begin
                        for (int i = 0; i < DIV; i++) wave.push_back({1'b0, 2'b00, m_data, 2'b10});
                        for (int i = 0; i < DIV; i++) wave.push_back({1'b0, 2'b00, m_data, 2'b11});
                    end
                    m_pend = 1'b0;
                end else if (q.size() > 0) begin
                    d      = q.pop_front();
                    m_data = d;
                    for (int i = 0; i < DIV; i++) wave.push_back({1'b0, 2'b00, d, 2'b00});
                    for (int i = 0; i < DIV; i++) wave.push_back({(i == DIV - 1), 2'b00, d, 2'b01});
                end
            end
            m_pend = m_pend || rst_req;
            if (acc) q.push_back(wr_data);
            if (wave.size() > 0) begin
                w        = wave.pop_front();
                exp_io   = w[7:0];
                cur_last = w[8];
                m_idle   = 1'b0;
            end else begin
                exp_io   = {2'b00, m_data, 2'b00};
                cur_last = 1'b0;
                m_idle   = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("calc_io_in", 32'(calc_io_in), 32'(exp_io));
            chk("level", 32'(level), 32'(q.size()));
            chk("wr_ready", 32'(wr_ready), 32'(q.size() != DEPTH));
            chk("busy", 32'(busy), 32'(!m_idle || m_pend));
`ifdef STACKCALC_FEEDER_CAPTURE_EN
            chk("result_valid", 32'(result_valid), 32'(exp_rv));
            chk("result", 32'(result), 32'(exp_res));
`endif
        end
    end

    task automatic wait_idle(input string name, input int budget);
        int k;
        k = 0;
        while ((busy || level != '0) && k < budget) begin
            tick();
            k++;
        end
        chk(name, 32'(k < budget), 32'd1);
    endtask

    initial begin
        logic [3:0] seen[$];
        bit         prev_clk;
        int         k;
        int         rst_cycles;

        rst = 1'b1; wr_valid = 1'b0; wr_data = 4'h0; rst_req = 1'b0; calc_io_out = 8'h00;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_io", 32'(calc_io_in), 32'h00);
        chk("reset_level", 32'(level), 32'd0);
        chk("reset_ready", 32'(wr_ready), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);

        // Single nibble: data at cycle 2, calc_clk high cycles 6..9, idle at cycle 10.
        tick(); wr_valid = 1'b1; wr_data = 4'hA;
        tick(); wr_valid = 1'b0;
        tick(); @(negedge clk); chk("nib_c2", 32'(calc_io_in), 32'h28);
        repeat (3) tick(); @(negedge clk); chk("nib_c5", 32'(calc_io_in), 32'h28);
        tick(); @(negedge clk); chk("nib_c6", 32'(calc_io_in), 32'h29);
        repeat (3) tick(); @(negedge clk); chk("nib_c9", 32'(calc_io_in), 32'h29);
        tick(); @(negedge clk);
        chk("nib_c10", 32'(calc_io_in), 32'h28);
        chk("nib_c10_busy", 32'(busy), 32'd0);

        // Full FIFO: pending reset request keeps the FSM away from the queue while filling.
        for (int i = 0; i < 9; i++) begin
            tick();
            wr_valid = 1'b1;
            wr_data  = 4'(i);
            rst_req  = (i == 0);
            if (i == 8) begin
                @(negedge clk);
                chk("full_level", 32'(level), 32'd8);
                chk("full_ready", 32'(wr_ready), 32'd0);
            end
        end
        tick(); wr_valid = 1'b0; rst_req = 1'b0;
        prev_clk = 1'b0;
        k = 0;
        while ((busy || level != '0) && k < 400) begin
            if (calc_io_in[0] && !prev_clk && !calc_io_in[1]) seen.push_back(calc_io_in[5:2]);
            prev_clk = calc_io_in[0];
            tick();
            k++;
        end
        chk("full_drain", 32'(k < 400), 32'd1);
        chk("full_count", 32'(seen.size()), 32'd8);
        for (int i = 0; i < 8 && i < seen.size(); i++) chk("full_order", 32'(seen[i]), 32'(i));

        // Reset request mid-HI: nibble finishes, then 2 calc periods of calc_rst, then queue resumes.
        for (int i = 5; i < 8; i++) begin
            tick(); wr_valid = 1'b1; wr_data = 4'(i);
        end
        tick(); wr_valid = 1'b0;
        k = 0;
        while (!(calc_io_in[0] && !calc_io_in[1]) && k < 100) begin tick(); k++; end
        chk("rreq_wait_hi", 32'(k < 100), 32'd1);
        rst_req = 1'b1;
        tick(); rst_req = 1'b0;
        rst_cycles = 0;
        k = 0;
        while ((busy || level != '0) && k < 400) begin
            if (calc_io_in[1]) rst_cycles++;
            tick();
            k++;
        end
        chk("rreq_drain", 32'(k < 400), 32'd1);
        chk("rreq_rst_cycles", 32'(rst_cycles), 32'(2 * RST_PER * DIV));

        // Synchronous reset while a nibble is in its LO half.
        tick(); wr_valid = 1'b1; wr_data = 4'h9;
        tick(); wr_data = 4'h3;
        tick(); wr_valid = 1'b0;
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        @(negedge clk);
        chk("srst_io", 32'(calc_io_in), 32'h00);
        chk("srst_level", 32'(level), 32'd0);
        for (int i = 0; i < 20; i++) begin
            tick();
            @(negedge clk);
            chk("srst_quiet", 32'(calc_io_in), 32'h00);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            tick();
            wr_valid    = 1'($urandom_range(0, 1));
            wr_data     = 4'($urandom);
            rst_req     = ($urandom_range(0, 39) == 0);
            rst         = ($urandom_range(0, 299) == 0);
            calc_io_out = 8'($urandom);
        end
        tick(); wr_valid = 1'b0; rst_req = 1'b0; rst = 1'b0;
        wait_idle("rand_drain", 600);

`ifdef STACKCALC_FEEDER_CAPTURE_EN
        tick(); wr_valid = 1'b1; wr_data = 4'h3; calc_io_out = 8'h3C;
        tick(); wr_valid = 1'b0;
        k = 0;
        while (!result_valid && k < 50) begin tick(); k++; end
        chk("cap_wait", 32'(k < 50), 32'd1);
        chk("cap_result", 32'(result), 32'h3C);
        tick();
        chk("cap_pulse_once", 32'(result_valid), 32'd0);
`endif

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
